// File: rtl/message_storage.sv
// Fixed 16-character message ROM ("HELLO, WORLD!   ") with registered character output.
// Optional MSG_SCROLL_EN adds a scroll offset that rotates the message without changing addr.
module message_storage #(
    parameter int              ADDR_W     = 4,
    parameter int              DATA_W     = 8,
    parameter logic [DATA_W-1:0] BLANK_CHAR = 8'h20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] display
`ifdef MSG_SCROLL_EN
    ,
    input  logic              scroll_step,
    output logic [ADDR_W-1:0] scroll_offset
`endif
);

    logic [ADDR_W-1:0] eff_addr;
    logic [7:0]        rom_char;

`ifdef MSG_SCROLL_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            scroll_offset <= '0;
        else if (scroll_step)
            scroll_offset <= scroll_offset + 1'b1;
    end

    // Natural 4-bit wrap gives the rotation; the offset used is the pre-increment value.
    assign eff_addr = addr + scroll_offset;
`else
    assign eff_addr = addr;
`endif

    always_comb begin
        rom_char = 8'h20;
        case (eff_addr)
            4'd0:    rom_char = 8'h48;
            4'd1:    rom_char = 8'h45;
            4'd2:    rom_char = 8'h4C;
            4'd3:    rom_char = 8'h4C;
            4'd4:    rom_char = 8'h4F;
            4'd5:    rom_char = 8'h2C;
            4'd6:    rom_char = 8'h20;
            4'd7:    rom_char = 8'h57;
            4'd8:    rom_char = 8'h4F;
            4'd9:    rom_char = 8'h52;
            4'd10:   rom_char = 8'h4C;
            4'd11:   rom_char = 8'h44;
            4'd12:   rom_char = 8'h21;
            default: rom_char = 8'h20;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            display <= BLANK_CHAR;
        else
            display <= DATA_W'(rom_char);
    end

endmodule

// File: tb/tb_message_storage.sv
// Self-checking bench for message_storage: table-driven reads through a scoreboard queue,
// plus hand-written reset, hold and (with MSG_SCROLL_EN) scroll sequences.
module tb_message_storage;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] addr;
    logic [7:0] display;
`ifdef MSG_SCROLL_EN
    logic       scroll_step;
    logic [3:0] scroll_offset;
`endif

    message_storage dut (
        .clk     (clk),
        .reset   (reset),
        .addr    (addr),
        .display (display)
`ifdef MSG_SCROLL_EN
        ,
        .scroll_step   (scroll_step),
        .scroll_offset (scroll_offset)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] addr;
        logic [7:0] exp;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] exp_q[$];
    int         pass_count  = 0;
    int         check_count = 0;
    string      msg;

    task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
        check_count++;
        if (act === exp)
            pass_count++;
        else
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Drive one address, wait for the edge that samples it, then compare against the scoreboard.
    task automatic apply_stimulus(input vec_t v, input int idx);
        logic [7:0] exp;
        addr = v.addr;
        exp_q.push_back(v.exp);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check_count++;
            $display("[TB] FAIL scoreboard_empty vec %0d: got nothing, expected an entry", idx);
        end else begin
            exp = exp_q.pop_front();
            check_output($sformatf("vec%0d_addr%0d", idx, v.addr), display, exp);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        msg   = "HELLO, WORLD!   ";
        reset = 1'b1;
        addr  = 4'd3;
`ifdef MSG_SCROLL_EN
        scroll_step = 1'b0;
`endif
        for (int i = 0; i < 16; i++)
            vecs.push_back('{addr: 4'(i), exp: msg[i]});
        vecs.push_back('{addr: 4'd15, exp: 8'h20});
        vecs.push_back('{addr: 4'd0,  exp: 8'h48});
        vecs.push_back('{addr: 4'd9,  exp: 8'h52});
        vecs.push_back('{addr: 4'd5,  exp: 8'h2C});

        repeat (3) @(posedge clk);
        #1;
        check_output("reset_hold", display, 8'h20);
`ifdef MSG_SCROLL_EN
        check_output("reset_offset", {4'h0, scroll_offset}, 8'h00);
`endif

        reset = 1'b0;
        foreach (vecs[i])
            apply_stimulus(vecs[i], i);

        // Asynchronous reset between edges: display must blank without a clock edge.
        #2;
        reset = 1'b1;
        #1;
        check_output("async_reset", display, 8'h20);

        // Latency and hold: new addr between edges must not disturb display until the edge.
        addr  = 4'd7;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_output("latency_addr7", display, 8'h57);
        #2;
        addr = 4'd12;
        #1;
        check_output("hold_before_edge", display, 8'h57);
        @(posedge clk);
        #1;
        check_output("after_edge_addr12", display, 8'h21);

`ifdef MSG_SCROLL_EN
        addr = 4'd0;
        @(posedge clk);
        #1;
        check_output("scroll_base", display, 8'h48);
        scroll_step = 1'b1;
        @(posedge clk);
        #1;
        scroll_step = 1'b0;
        check_output("scroll_old_offset", display, 8'h48);
        check_output("scroll_offset_1", {4'h0, scroll_offset}, 8'h01);
        @(posedge clk);
        #1;
        check_output("scroll_new_offset", display, 8'h45);
        for (int i = 0; i < 15; i++) begin
            scroll_step = 1'b1;
            @(posedge clk);
            #1;
            scroll_step = 1'b0;
        end
        check_output("scroll_wrap_offset", {4'h0, scroll_offset}, 8'h00);
        @(posedge clk);
        #1;
        check_output("scroll_wrap_display", display, 8'h48);

        for (int i = 0; i < 5; i++) begin
            scroll_step = 1'b1;
            @(posedge clk);
            #1;
            scroll_step = 1'b0;
        end
        check_output("scroll_offset_5", {4'h0, scroll_offset}, 8'h05);
        @(posedge clk);
        #1;
        check_output("scroll_display_5", display, msg[5]);
        #2;
        reset = 1'b1;
        #1;
        check_output("scroll_reset_offset", {4'h0, scroll_offset}, 8'h00);
        check_output("scroll_reset_display", display, 8'h20);
        reset = 1'b0;
        addr  = 4'd0;
        @(posedge clk);
        #1;
        check_output("scroll_after_reset", display, 8'h48);
`endif

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
